// File: rtl/btn_pkg.sv
// Shared constants and types for the ULX3S push-button debouncer.
package btn_pkg;

    localparam int BTN_DEBOUNCE_CYCLES_DEF = 250000;   // 10 ms at 25 MHz
    localparam int BTN_REPEAT_DELAY_DEF    = 12500000; // 500 ms
    localparam int BTN_REPEAT_PERIOD_DEF   = 2500000;  // 100 ms

    // btn[0] (PWR) reads 0 when pressed; the rest are active-high.
    localparam logic [6:0] BTN_ACTIVE_LOW_MASK_ULX3S = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } btn_rpt_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, stable-count debouncer and press/release pulses.
// Optional auto-repeat of the press pulse when BTN_DEBOUNCE_REPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF
`ifdef BTN_DEBOUNCE_REPEAT_EN
   ,parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF
   ,parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk_25mhz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          rpt_fire;

    always_comb accept = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX);

    btn_rpt_state_t rpt_state, rpt_state_d;
    logic [RW-1:0]  rpt_cnt, rpt_cnt_d;

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            rpt_state <= IDLE;
            rpt_cnt   <= '0;
        end else begin
            rpt_state <= rpt_state_d;
            rpt_cnt   <= rpt_cnt_d;
        end
    end

    always_comb begin
        rpt_state_d = rpt_state;
        rpt_cnt_d   = rpt_cnt + 1'b1;
        rpt_fire    = 1'b0;
        case (rpt_state)
            IDLE: begin
                rpt_cnt_d = '0;
                if (accept && s2) rpt_state_d = DELAY;
            end
            DELAY: begin
                if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
                    rpt_fire    = 1'b1;
                    rpt_state_d = REPEAT;
                    rpt_cnt_d   = '0;
                end
            end
            REPEAT: begin
                if (rpt_cnt == RW'(REPEAT_PERIOD - 1)) begin
                    rpt_fire  = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
            default: begin
                rpt_state_d = IDLE;
                rpt_cnt_d   = '0;
            end
        endcase
        // An accepted release overrides any repeat pulse due in the same cycle.
        if (accept && !s2) begin
            rpt_state_d = IDLE;
            rpt_cnt_d   = '0;
            rpt_fire    = 1'b0;
        end
    end
`else
    always_comb rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press <= (accept && s2) || rpt_fire;
            rel   <= accept && !s2;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// ULX3S button front end: polarity normalisation plus N_BTN independent debounce channels.
// Define BTN_DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 7,
    parameter int               DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = N_BTN'(BTN_ACTIVE_LOW_MASK_ULX3S),
    parameter int               REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
    parameter int               REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_debounce: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic [N_BTN-1:0] raw_norm;

    always_comb raw_norm = btn_raw ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
           ,.REPEAT_DELAY   (REPEAT_DELAY)
           ,.REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_25mhz(clk_25mhz),
            .rst      (rst),
            .raw      (raw_norm[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .rel      (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: expected pulse events are queued by stimulus, checked by a monitor.
module tb_btn_debounce;

    localparam int N = 7;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] level;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t sb[$];

    btn_debounce #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW_MASK(7'b0000001),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk_25mhz  (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                             input logic [N-1:0] l);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.level = l;
        sb.push_back(e);
    endtask

    // Monitor: every cycle carrying a pulse must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if ((btn_press | btn_release) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {18'd0, btn_press, btn_release}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("press", 32'(btn_press), 32'(e.press));
                chk("release", 32'(btn_release), 32'(e.rel));
                chk("level", 32'(btn_level), 32'(e.level));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        btn_raw = 7'b0000001;
        at_cycle(3);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_press", 32'(btn_press), 32'd0);
        chk("rst_release", 32'(btn_release), 32'd0);
        at_cycle(4);
        rst = 1'b0;

        // Clean press/release on channel 1
        at_cycle(10);
        btn_raw[1] = 1'b1;
        expect_ev(16, 7'b0000010, '0, 7'b0000010);
`ifdef BTN_DEBOUNCE_REPEAT_EN
        expect_ev(26, 7'b0000010, '0, 7'b0000010);
        expect_ev(29, 7'b0000010, '0, 7'b0000010);
        expect_ev(32, 7'b0000010, '0, 7'b0000010);
        expect_ev(35, 7'b0000010, '0, 7'b0000010);
`endif
        at_cycle(30);
        btn_raw[1] = 1'b0;
        expect_ev(36, '0, 7'b0000010, '0);

        // Bounce on channel 2: last 0->1 edge at cycle 45
        at_cycle(40); btn_raw[2] = 1'b1;
        at_cycle(41); btn_raw[2] = 1'b0;
        at_cycle(42); btn_raw[2] = 1'b1;
        at_cycle(44); btn_raw[2] = 1'b0;
        at_cycle(45); btn_raw[2] = 1'b1;
        expect_ev(51, 7'b0000100, '0, 7'b0000100);
        at_cycle(55);
        btn_raw[2] = 1'b0;
        expect_ev(61, '0, 7'b0000100, '0);

        // 3-cycle glitch on channel 3 must be rejected
        at_cycle(70); btn_raw[3] = 1'b1;
        at_cycle(73); btn_raw[3] = 1'b0;
        at_cycle(80);
        chk("glitch_level", 32'(btn_level), 32'd0);

        // Active-low channel 0
        at_cycle(90);
        btn_raw[0] = 1'b0;
        expect_ev(96, 7'b0000001, '0, 7'b0000001);
        at_cycle(97);
        chk("active_low_level", 32'(btn_level[0]), 32'd1);
        at_cycle(100);
        btn_raw[0] = 1'b1;
        expect_ev(106, '0, 7'b0000001, '0);

        // Reset while channel 4 is held and accepted
        at_cycle(110);
        btn_raw[4] = 1'b1;
        expect_ev(116, 7'b0010000, '0, 7'b0010000);
        at_cycle(120);
        rst = 1'b1;
        at_cycle(121);
        rst = 1'b0;
        chk("midrst_level", 32'(btn_level), 32'd0);
        chk("midrst_press", 32'(btn_press), 32'd0);
        chk("midrst_release", 32'(btn_release), 32'd0);
        expect_ev(127, 7'b0010000, '0, 7'b0010000);
`ifdef BTN_DEBOUNCE_REPEAT_EN
        expect_ev(137, 7'b0010000, '0, 7'b0010000);
        expect_ev(140, 7'b0010000, '0, 7'b0010000);
`endif
        at_cycle(135);
        btn_raw[4] = 1'b0;
        expect_ev(141, '0, 7'b0010000, '0);

        // Channel 5 hold: release accepted exactly when a repeat pulse would be due
        at_cycle(150);
        btn_raw[5] = 1'b1;
        expect_ev(156, 7'b0100000, '0, 7'b0100000);
`ifdef BTN_DEBOUNCE_REPEAT_EN
        expect_ev(166, 7'b0100000, '0, 7'b0100000);
        expect_ev(169, 7'b0100000, '0, 7'b0100000);
        expect_ev(172, 7'b0100000, '0, 7'b0100000);
`endif
        at_cycle(169);
        btn_raw[5] = 1'b0;
        expect_ev(175, '0, 7'b0100000, '0);

        // Simultaneous edges on channels 1 and 6
        at_cycle(190);
        btn_raw[1] = 1'b1;
        btn_raw[6] = 1'b1;
        expect_ev(196, 7'b1000010, '0, 7'b1000010);
        at_cycle(200);
        btn_raw[1] = 1'b0;
        btn_raw[6] = 1'b0;
        expect_ev(206, '0, 7'b1000010, '0);

        at_cycle(215);
        chk("missing_events", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Per-button synchronizer, debouncer and edge detector for the ULX3S push-buttons. Sits between the raw `btn[6:0]` pads and any consumer logic, such as LED/counter demos and mode selection. For each button it provides:
- a clean, polarity-normalised level;
- a single-cycle press pulse;
- a single-cycle release pulse.

All logic runs in the 25 MHz board clock domain.

## Interface
Parameters:
- `N_BTN`, 7, number of button channels.
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required to accept a new level (10 ms at 25 MHz); legal range ≥ 2.
- `ACTIVE_LOW_MASK`, 7'b0000001, per-channel: 1 = pad reads 0 when pressed (btn[0] PWR is active-low), inverted before debouncing.
- `REPEAT_DELAY`, 12500000, cycles held before the first auto-repeat pulse (500 ms); used only with autorepeat.
- `REPEAT_PERIOD`, 2500000, cycles between subsequent auto-repeat pulses (100 ms); used only with autorepeat.

Ports:
- `clk_25mhz`  in  1  board clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  N_BTN  asynchronous button pads.
- `btn_level`  out  N_BTN  debounced state, 1 = pressed.
- `btn_press`  out  N_BTN  one-cycle pulse on accepted press (plus repeats if enabled).
- `btn_release`  out  N_BTN  one-cycle pulse on accepted release.

## Operation
- Each channel is independent and identical.
- Polarity: `btn_raw[i]` is XORed with `ACTIVE_LOW_MASK[i]`, then passed through a 2-flop synchronizer (`s1`, `s2`).
- Counter `cnt` has width $clog2(DEBOUNCE_CYCLES). Each cycle:
  - if `s2 == btn_level`, then `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`, then `btn_level <= s2` and `cnt <= 0`;
  - else `cnt <= cnt + 1`.
- Any bounce back to the current level restarts the count from 0. A glitch shorter than `DEBOUNCE_CYCLES` never changes `btn_level`.
- Pulses are registered:
  - `btn_press[i]` is 1 in exactly the first cycle `btn_level[i]` reads 1;
  - `btn_release[i]` is 1 in exactly the first cycle `btn_level[i]` reads 0.
- Press and release are never both high on one channel in one cycle.
- Reset, including mid-count or mid-press:
  - `s1`, `s2`, `cnt`, `btn_level`, `btn_press`, `btn_release` all go to 0, and any repeat state is cleared;
  - no release pulse is generated by reset;
  - a button still held after reset is re-accepted as a fresh press after the normal latency.

## Timing
- Raw edge at clock edge t, with the input stable afterwards:
  - `s2` reflects it after edge t+2;
  - `btn_level` and the matching pulse update after edge t+2+`DEBOUNCE_CYCLES`.
- Total latency is `DEBOUNCE_CYCLES`+2 cycles, constant per channel.
- Pulse width is exactly 1 cycle.
- Minimum accepted hold time is `DEBOUNCE_CYCLES` cycles. The minimum spacing between a press pulse and a release pulse on one channel is `DEBOUNCE_CYCLES` cycles.
- Simultaneous edges on several channels produce simultaneous pulses; no arbitration.

## Configuration
- Macro: `BTN_DEBOUNCE_REPEAT_EN`.
- Defined: per-channel repeat counter with states IDLE → DELAY → REPEAT.
  - The accepted press pulse enters DELAY with count 0.
  - After `REPEAT_DELAY` cycles of held level, `btn_press` pulses and the channel enters REPEAT.
  - In REPEAT, `btn_press` pulses every `REPEAT_PERIOD` cycles.
  - Release (the `btn_level` falling edge) returns the channel to IDLE in the same cycle; no repeat pulse occurs in that cycle.
  - Reset returns the channel to IDLE.
- Undefined: no repeat logic is synthesised; `REPEAT_*` parameters are ignored; `btn_press` fires once per accepted press.

## Structure
- Package `btn_pkg` holds:
  - default constants `BTN_DEBOUNCE_CYCLES_DEF`, `BTN_REPEAT_DELAY_DEF`, `BTN_REPEAT_PERIOD_DEF`;
  - `BTN_ACTIVE_LOW_MASK_ULX3S`;
  - the repeat-state enum `btn_rpt_state_t` (IDLE, DELAY, REPEAT).
- Sub-module `btn_debounce_ch`: one channel (sync, counter, level, pulses, optional repeat). The top instantiates `N_BTN` copies in a generate loop and applies the polarity mask.

## Test plan
Directed scenarios, with `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3 unless stated.
- Clean press then release on channel 1:
  - `btn_raw[1]` 0→1 at cycle 10 → `btn_level[1]`=1 and `btn_press[1]`=1 for one cycle at cycle 16;
  - release at cycle 30 → `btn_release[1]` pulse at cycle 36.
- Bounce on channel 2: pulses 1,0,1,1,0 cycle by cycle, then steady 1 → no output change until 6 cycles after the last 0→1 edge; exactly one press pulse.
- Glitch on channel 3: 3-cycle high pulse → `btn_level[3]` stays 0, no pulses.
- Active-low channel 0: `btn_raw[0]` 1→0 → press pulse after 6 cycles; `btn_level[0]`=1 while `btn_raw[0]`=0.
- Reset mid-operation: hold channel 4 pressed with `btn_level`=1, assert `rst` for 1 cycle → all outputs 0 next cycle with no release pulse; the press re-accepted 6 cycles after `rst` deasserts.
- Autorepeat (only with `BTN_DEBOUNCE_REPEAT_EN`): hold channel 5 pressed → press pulses at accept cycle A, A+10, A+13, A+16; release → no further pulses and one release pulse.
